// File: rtl/pipe_rx_pkg.sv
// Shared header layout, FSM states and helpers for the pipe-in command parser.
// PIPE_RX_CHECKSUM_EN adds the CHECK state for a trailing XOR checksum word.
package pipe_rx_pkg;

  localparam int HDR_ADDR_HI = 15;
  localparam int HDR_ADDR_LO = 8;
  localparam int HDR_CHAN_HI = 7;
  localparam int HDR_CHAN_LO = 4;
  localparam int HDR_RSVD_HI = 3;
  localparam int HDR_RSVD_LO = 2;
  localparam int HDR_LEN_HI  = 1;
  localparam int HDR_LEN_LO  = 0;

  localparam int LEN_MAX = 3;
  localparam int LEN_W   = $clog2(LEN_MAX + 1);

  localparam logic [15:0] CHK_SEED = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
`ifdef PIPE_RX_CHECKSUM_EN
    ST_CHECK  = 2'd2,
`endif
    ST_COMMIT = 2'd3
  } state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    sat_inc8 = (v == 8'hFF) ? v : v + 8'h01;
  endfunction

endpackage

// File: rtl/pipe_rx_fifo.sv
// Single-clock first-word-fall-through FIFO with a registered occupancy count.
// Writes are refused whenever the registered count says full, even alongside a pop.
module pipe_rx_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 16
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rd_en_i,
  output logic [W-1:0] rd_data_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          push_s;
  logic          pop_s;

  always_comb begin
    full_o    = (count_q == CW'(DEPTH));
    empty_o   = (count_q == '0);
    push_s    = wr_en_i & ~full_o;
    pop_s     = rd_en_i & ~empty_o;
    count_d   = count_q + CW'(push_s) - CW'(pop_s);
    rd_data_o = mem_q[rd_ptr_q];
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pipe_rx_cmd_parser.sv
// Decodes host pipe-in packets (header + LEN words, MSW first) into parameter writes.
// Define PIPE_RX_CHECKSUM_EN to require a trailing XOR checksum word per packet.
module pipe_rx_cmd_parser #(
  parameter int W_EP       = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int W_PARAM    = 3 * W_EP
) (
  input  logic               clk50_in,
  input  logic               rst_n_in,
  input  logic               pipe_write_in,
  input  logic [W_EP-1:0]    pipe_data_in,
  output logic               pipe_full_out,
  output logic               param_valid_out,
  input  logic               param_ready_in,
  output logic [7:0]         param_addr_out,
  output logic [3:0]         param_chan_out,
  output logic [W_PARAM-1:0] param_data_out,
  output logic [7:0]         err_count_out,
  output logic               overflow_out
);

  import pipe_rx_pkg::*;

  logic [W_EP-1:0]    fifo_data_s;
  logic               fifo_empty_s;
  logic               fifo_full_s;
  logic               pop_s;
  logic [LEN_W-1:0]   hdr_len_s;
  logic [W_PARAM-1:0] acc_d;

  state_e             state_q;
  logic [LEN_W-1:0]   rem_q;
  logic [W_PARAM-1:0] acc_q;
  logic [7:0]         addr_q;
  logic [3:0]         chan_q;
  logic               valid_q;
  logic [7:0]         err_q;
  logic               ovf_q;
`ifdef PIPE_RX_CHECKSUM_EN
  logic [W_EP-1:0]    chk_q;
`endif

  pipe_rx_fifo #(
    .W     (W_EP),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk50_in),
    .rst_n_i   (rst_n_in),
    .wr_en_i   (pipe_write_in),
    .wr_data_i (pipe_data_in),
    .rd_en_i   (pop_s),
    .rd_data_o (fifo_data_s),
    .empty_o   (fifo_empty_s),
    .full_o    (fifo_full_s)
  );

  // Every state except COMMIT consumes one word whenever one is available.
  always_comb begin
    pop_s     = 1'b0;
    hdr_len_s = fifo_data_s[HDR_LEN_HI:HDR_LEN_LO];
    acc_d     = {acc_q[W_PARAM-W_EP-1:0], fifo_data_s};
    case (state_q)
      ST_IDLE:   pop_s = ~fifo_empty_s;
      ST_DATA:   pop_s = ~fifo_empty_s;
`ifdef PIPE_RX_CHECKSUM_EN
      ST_CHECK:  pop_s = ~fifo_empty_s;
`endif
      ST_COMMIT: pop_s = 1'b0;
      default:   pop_s = 1'b0;
    endcase
  end

  always_ff @(posedge clk50_in) begin
    if (!rst_n_in) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      acc_q   <= '0;
      addr_q  <= 8'h00;
      chan_q  <= 4'h0;
      valid_q <= 1'b0;
      err_q   <= 8'h00;
      ovf_q   <= 1'b0;
`ifdef PIPE_RX_CHECKSUM_EN
      chk_q   <= '0;
`endif
    end else begin
      if (pipe_write_in && fifo_full_s) begin
        ovf_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty_s) begin
            if (hdr_len_s == '0) begin
              err_q <= sat_inc8(err_q);
            end else begin
              addr_q  <= fifo_data_s[HDR_ADDR_HI:HDR_ADDR_LO];
              chan_q  <= fifo_data_s[HDR_CHAN_HI:HDR_CHAN_LO];
              rem_q   <= hdr_len_s;
              acc_q   <= '0;
`ifdef PIPE_RX_CHECKSUM_EN
              chk_q   <= W_EP'(CHK_SEED) ^ fifo_data_s;
`endif
              state_q <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (!fifo_empty_s) begin
            acc_q <= acc_d;
            rem_q <= rem_q - LEN_W'(1);
`ifdef PIPE_RX_CHECKSUM_EN
            chk_q <= chk_q ^ fifo_data_s;
`endif
            if (rem_q == LEN_W'(1)) begin
`ifdef PIPE_RX_CHECKSUM_EN
              state_q <= ST_CHECK;
`else
              // Raising valid on the last pop gives the two-cycle write-to-valid latency.
              state_q <= ST_COMMIT;
              valid_q <= 1'b1;
`endif
            end
          end
        end
`ifdef PIPE_RX_CHECKSUM_EN
        ST_CHECK: begin
          if (!fifo_empty_s) begin
            if (fifo_data_s == chk_q) begin
              state_q <= ST_COMMIT;
              valid_q <= 1'b1;
            end else begin
              err_q   <= sat_inc8(err_q);
              state_q <= ST_IDLE;
            end
          end
        end
`endif
        ST_COMMIT: begin
          if (param_ready_in) begin
            valid_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign pipe_full_out   = fifo_full_s;
  assign param_valid_out = valid_q;
  assign param_addr_out  = addr_q;
  assign param_chan_out  = chan_q;
  assign param_data_out  = acc_q;
  assign err_count_out   = err_q;
  assign overflow_out    = ovf_q;

endmodule

// File: tb/tb_pipe_rx_cmd_parser.sv
// Directed bench for pipe_rx_cmd_parser: a packet table plus hand-written
// sequences for stall, overflow, reset, saturation and checksum corners.
module tb_pipe_rx_cmd_parser;

  localparam int W_EP  = 16;
  localparam int DEPTH = 16;
  localparam int WP    = 48;
`ifdef PIPE_RX_CHECKSUM_EN
  localparam int CHK_EXTRA = 1;
`else
  localparam int CHK_EXTRA = 0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            pipe_write_in;
  logic [W_EP-1:0] pipe_data_in;
  logic            pipe_full_out;
  logic            param_valid_out;
  logic            param_ready_in;
  logic [7:0]      param_addr_out;
  logic [3:0]      param_chan_out;
  logic [WP-1:0]   param_data_out;
  logic [7:0]      err_count_out;
  logic            overflow_out;

  always #5 clk = ~clk;

  pipe_rx_cmd_parser #(
    .W_EP       (W_EP),
    .FIFO_DEPTH (DEPTH),
    .W_PARAM    (WP)
  ) dut (
    .clk50_in        (clk),
    .rst_n_in        (rst_n),
    .pipe_write_in   (pipe_write_in),
    .pipe_data_in    (pipe_data_in),
    .pipe_full_out   (pipe_full_out),
    .param_valid_out (param_valid_out),
    .param_ready_in  (param_ready_in),
    .param_addr_out  (param_addr_out),
    .param_chan_out  (param_chan_out),
    .param_data_out  (param_data_out),
    .err_count_out   (err_count_out),
    .overflow_out    (overflow_out)
  );

  typedef struct packed {
    logic [15:0] hdr;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [15:0] d2;
    logic [7:0]  addr;
    logic [3:0]  chan;
    logic [47:0] data;
  } vec_t;

  vec_t vecs [6];

  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;
  longint mon_cyc [$];
  logic [47:0] mon_data [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Log every accepted parameter write with its cycle number.
  always @(negedge clk) begin
    if (rst_n && param_valid_out && param_ready_in) begin
      mon_cyc.push_back(cyc);
      mon_data.push_back(param_data_out);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [15:0] w);
    pipe_write_in = 1'b1;
    pipe_data_in  = w;
    tick();
    pipe_write_in = 1'b0;
  endtask

  task automatic send(input logic [15:0] hdr, input logic [15:0] d0,
                      input logic [15:0] d1, input logic [15:0] d2);
    logic [15:0] x;
    logic [15:0] dw [3];
    int len;
    dw[0] = d0; dw[1] = d1; dw[2] = d2;
    len = int'(hdr[1:0]);
    x = hdr;
    wr(hdr);
    for (int i = 0; i < len; i++) begin
      wr(dw[i]);
      x = x ^ dw[i];
    end
`ifdef PIPE_RX_CHECKSUM_EN
    if (len != 0) wr(x);
`endif
  endtask

  // Sends one packet with ready=1 and checks latency, fields and pulse width.
  task automatic run_vec(input vec_t v, input string tag);
    send(v.hdr, v.d0, v.d1, v.d2);
    chk({tag, "_early"}, 64'(param_valid_out), 64'd0);
    tick();
    chk({tag, "_valid"}, 64'(param_valid_out), 64'd1);
    chk({tag, "_addr"},  64'(param_addr_out),  64'(v.addr));
    chk({tag, "_chan"},  64'(param_chan_out),  64'(v.chan));
    chk({tag, "_data"},  64'(param_data_out),  64'(v.data));
    tick();
    chk({tag, "_drop"},  64'(param_valid_out), 64'd0);
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (!param_valid_out && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;

    vecs[0] = '{16'h2313, 16'hABCD, 16'h1234, 16'h5678, 8'h23, 4'h1, 48'hABCD_1234_5678};
    vecs[1] = '{16'h0F51, 16'h00FF, 16'h0000, 16'h0000, 8'h0F, 4'h5, 48'h0000_0000_00FF};
    vecs[2] = '{16'hA5C2, 16'h8001, 16'h7FFE, 16'h0000, 8'hA5, 4'hC, 48'h0000_8001_7FFE};
    vecs[3] = '{16'hFF0E, 16'hFFFF, 16'h0000, 16'h0000, 8'hFF, 4'h0, 48'h0000_FFFF_0000};
    vecs[4] = '{16'h0173, 16'h0001, 16'h0002, 16'h0003, 8'h01, 4'h7, 48'h0001_0002_0003};
    vecs[5] = '{16'h00F1, 16'h8000, 16'h0000, 16'h0000, 8'h00, 4'hF, 48'h0000_0000_8000};

    rst_n          = 1'b0;
    pipe_write_in  = 1'b0;
    pipe_data_in   = '0;
    param_ready_in = 1'b1;
    tick(); tick(); tick();
    chk("rst_valid", 64'(param_valid_out), 64'd0);
    chk("rst_addr",  64'(param_addr_out),  64'd0);
    chk("rst_chan",  64'(param_chan_out),  64'd0);
    chk("rst_data",  64'(param_data_out),  64'd0);
    chk("rst_err",   64'(err_count_out),   64'd0);
    chk("rst_ovf",   64'(overflow_out),    64'd0);
    chk("rst_full",  64'(pipe_full_out),   64'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Consumer stall: output must hold while a second packet queues up.
    param_ready_in = 1'b0;
    send(16'h0F51, 16'h00FF, 16'h0000, 16'h0000);
    tick();
    send(16'h2313, 16'hABCD, 16'h1234, 16'h5678);
    for (int i = 0; i < 10; i++) begin
      chk("stall_hold", {15'd0, param_valid_out, param_addr_out, param_data_out},
          {15'd0, 1'b1, 8'h0F, 48'h0000_0000_00FF});
      tick();
    end
    param_ready_in = 1'b1;
    tick();
    chk("stall_release", 64'(param_valid_out), 64'd0);
    wait_valid(20, n);
    chk("stall_next_lat", 64'(n), 64'(4 + CHK_EXTRA));
    chk("stall_next_data", 64'(param_data_out), 64'hABCD_1234_5678);
    tick();

    // LEN=0 header counts as malformed; the following packet is unaffected.
    wr(16'h4000);
    tick(); tick();
    chk("len0_err",   64'(err_count_out),   64'd1);
    chk("len0_valid", 64'(param_valid_out), 64'd0);
    run_vec(vecs[0], "after_len0");

    // Back-to-back LEN=2 packets: one write every LEN+2 cycles.
    tick(); tick();
    mon_cyc.delete();
    mon_data.delete();
    send(16'h1102, 16'h0001, 16'h0002, 16'h0000);
    send(16'h2212, 16'h0003, 16'h0004, 16'h0000);
    send(16'h3322, 16'h0005, 16'h0006, 16'h0000);
    for (int i = 0; i < 20; i++) tick();
    chk("b2b_count", 64'(mon_cyc.size()), 64'd3);
    if (mon_cyc.size() == 3) begin
      chk("b2b_gap1", 64'(mon_cyc[1] - mon_cyc[0]), 64'(4 + CHK_EXTRA));
      chk("b2b_gap2", 64'(mon_cyc[2] - mon_cyc[1]), 64'(4 + CHK_EXTRA));
      chk("b2b_d0", 64'(mon_data[0]), 64'h0000_0001_0002);
      chk("b2b_d1", 64'(mon_data[1]), 64'h0000_0003_0004);
      chk("b2b_d2", 64'(mon_data[2]), 64'h0000_0005_0006);
    end

    // Overflow: parser parked in COMMIT, FIFO filled past its depth.
    do_reset();
    param_ready_in = 1'b0;
    send(16'h0F51, 16'h00FF, 16'h0000, 16'h0000);
    tick(); tick();
    for (int i = 0; i < DEPTH - 1; i++) wr(16'h4000);
    chk("ovf_not_full", 64'(pipe_full_out), 64'd0);
    wr(16'h4000);
    chk("ovf_full",     64'(pipe_full_out), 64'd1);
    chk("ovf_clear",    64'(overflow_out),  64'd0);
    wr(16'h4000);
    chk("ovf_set",      64'(overflow_out),  64'd1);
    wr(16'h4000);
    wr(16'h4000);
    chk("ovf_full2",    64'(pipe_full_out), 64'd1);
    param_ready_in = 1'b1;
    tick();
    wr(16'h4000);
    for (int i = 0; i < 24; i++) tick();
    chk("ovf_drained_err", 64'(err_count_out), 64'(DEPTH));
    chk("ovf_sticky",      64'(overflow_out),  64'd1);
    chk("ovf_empty_full",  64'(pipe_full_out), 64'd0);

    // Reset mid-packet discards it; next word is a header.
    wr(16'h2313);
    wr(16'hABCD);
    mon_cyc.delete();
    mon_data.delete();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_valid", 64'(param_valid_out), 64'd0);
    chk("mid_rst_err",   64'(err_count_out),   64'd0);
    chk("mid_rst_ovf",   64'(overflow_out),    64'd0);
    chk("mid_rst_data",  64'(param_data_out),  64'd0);
    run_vec(vecs[2], "after_rst");
    tick(); tick();
    chk("after_rst_count", 64'(mon_cyc.size()), 64'd1);

    // Error counter saturates at 255.
    do_reset();
    for (int i = 0; i < 254; i++) wr(16'h4000);
    tick(); tick(); tick();
    chk("sat_254", 64'(err_count_out), 64'd254);
    wr(16'h4000);
    tick(); tick(); tick();
    chk("sat_255", 64'(err_count_out), 64'd255);
    for (int i = 0; i < 5; i++) wr(16'h4000);
    tick(); tick(); tick();
    chk("sat_hold", 64'(err_count_out), 64'd255);
    chk("sat_no_ovf", 64'(overflow_out), 64'd0);

`ifdef PIPE_RX_CHECKSUM_EN
    // Explicit checksum words: good one commits, bad one is counted.
    do_reset();
    mon_cyc.delete();
    mon_data.delete();
    wr(16'h1011);
    wr(16'h0005);
    wr(16'h1014);
    tick();
    chk("cks_valid", 64'(param_valid_out), 64'd1);
    chk("cks_data",  64'(param_data_out),  64'h5);
    tick();
    wr(16'h1011);
    wr(16'h0005);
    wr(16'h1015);
    for (int i = 0; i < 6; i++) tick();
    chk("cks_bad_count", 64'(mon_cyc.size()), 64'd1);
    chk("cks_bad_err",   64'(err_count_out),  64'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
